// File: rtl/fadd_share_arbiter.sv
// Round-robin sharing of one two-stage FP32 adder (fadd_p2) among NREQ requesters.
// A tag pipeline running alongside the adder steers each result into its owner's response slot.

module fadd_p2 (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] y_q, y_d;
    logic        ovf_q, ovf_d;

    logic        sa, sb, sl, ss, swap, res_sign;
    logic        a_inf, b_inf, a_nan, b_nan;
    logic [7:0]  ea, eb, el, es, diff;
    logic [23:0] ma, mb, ml, ms;
    logic [26:0] ext_l, ext_s, lost_mask, norm;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [9:0]  e_n, e_f;
    logic        rnd_up;
    logic [24:0] m_r;
    logic [22:0] frac;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        a_d   = x1;
        b_d   = x2;
        sa    = a_q[31];
        sb    = b_q[31];
        ea    = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
        eb    = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
        ma    = {(a_q[30:23] != 8'd0), a_q[22:0]};
        mb    = {(b_q[30:23] != 8'd0), b_q[22:0]};
        a_inf = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

        swap = {eb, mb} > {ea, ma};
        sl   = swap ? sb : sa;
        ss   = swap ? sa : sb;
        el   = swap ? eb : ea;
        es   = swap ? ea : eb;
        ml   = swap ? mb : ma;
        ms   = swap ? ma : mb;
        diff = el - es;

        // Three extra bits below the mantissa hold guard, round and sticky.
        ext_l     = {ml, 3'b000};
        lost_mask = '0;
        if (diff >= 8'd27) begin
            ext_s = {26'd0, |ms};
        end else begin
            lost_mask = (27'd1 << diff[4:0]) - 27'd1;
            ext_s     = ({ms, 3'b000} >> diff[4:0])
                      | {26'd0, |({ms, 3'b000} & lost_mask)};
        end
        sum = (sl ^ ss) ? ({1'b0, ext_l} - {1'b0, ext_s})
                        : ({1'b0, ext_l} + {1'b0, ext_s});

        lz  = lzc27(sum[26:0]);
        sh  = '0;
        e_n = {2'b00, el};
        if (sum[27]) begin
            norm = {sum[27:2], |sum[1:0]};
            e_n  = {2'b00, el} + 10'd1;
        end else begin
            // Left shift stops at exponent 1 so tiny results come out subnormal.
            sh   = ((el - 8'd1) < {3'd0, lz}) ? 5'(el - 8'd1) : lz;
            norm = sum[26:0] << sh;
            e_n  = {2'b00, el} - {5'd0, sh};
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        m_r    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
        if (m_r[24]) begin
            e_f  = e_n + 10'd1;
            frac = '0;
        end else begin
            e_f  = m_r[23] ? e_n : 10'd0;
            frac = m_r[22:0];
        end
        res_sign = (sum == 28'd0) ? (sa & sb) : sl;

        y_d   = {res_sign, e_f[7:0], frac};
        ovf_d = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y_d = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            y_d = {(a_inf ? sa : sb), 8'hFF, 23'd0};
        end else if (e_f >= 10'd255) begin
            y_d   = {sl, 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_q   <= '0;
            b_q   <= '0;
            y_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            y_q   <= y_d;
            ovf_q <= ovf_d;
        end
    end

    assign y   = y_q;
    assign ovf = ovf_q;
endmodule

module fadd_share_arbiter #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [32*NREQ-1:0]   rsp_y,
    output logic [NREQ-1:0]      rsp_ovf,
    output logic                 busy,
    output logic [31:0]          issue_count
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } slot_state_e;

    slot_state_e        state_q [NREQ];
    slot_state_e        state_d [NREQ];
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [31:0]        issue_count_q, issue_count_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [IDW-1:0]     tag_id_q [LATENCY];
    logic [IDW-1:0]     tag_id_d [LATENCY];
    logic [31:0]        rsp_y_q [NREQ];
    logic [31:0]        rsp_y_d [NREQ];
    logic [NREQ-1:0]    rsp_ovf_q, rsp_ovf_d;

    logic               grant_any;
    logic [IDW-1:0]     grant_id;
    logic [NREQ-1:0]    grant_oh;
    int                 scan_idx;
    logic [31:0]        add_x1, add_x2, add_y;
    logic               add_ovf;
    logic               ret_vld;
    logic [IDW-1:0]     ret_id;

    fadd_p2 u_fadd (
        .clk  (clk),
        .rstn (rstn),
        .x1   (add_x1),
        .x2   (add_x2),
        .y    (add_y),
        .ovf  (add_ovf)
    );

    // Scan starts at the pointer so the last winner drops to lowest priority.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        grant_oh  = '0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % NREQ;
            if (!grant_any && req_valid[scan_idx] && (state_q[scan_idx] == S_IDLE)) begin
                grant_any = 1'b1;
                grant_id  = IDW'(scan_idx);
            end
        end
        if (grant_any) begin
            grant_oh[grant_id] = 1'b1;
        end

        add_x1 = '0;
        add_x2 = '0;
        if (grant_any) begin
            add_x1 = req_x1[32*grant_id +: 32];
            add_x2 = req_x2[32*grant_id +: 32];
        end
    end

    assign req_ready = grant_oh;
    assign ret_vld   = tag_vld_q[LATENCY-1];
    assign ret_id    = tag_id_q[LATENCY-1];

    always_comb begin
        ptr_d         = ptr_q;
        issue_count_d = issue_count_q;
        rsp_ovf_d     = rsp_ovf_q;
        for (int i = 0; i < NREQ; i++) begin
            state_d[i] = state_q[i];
            rsp_y_d[i] = rsp_y_q[i];
        end

        tag_vld_d[0] = grant_any;
        tag_id_d[0]  = grant_id;
        for (int s = 1; s < LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        if (grant_any) begin
            state_d[grant_id] = S_BUSY;
            ptr_d             = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
            issue_count_d     = issue_count_q + 32'd1;
        end

        for (int i = 0; i < NREQ; i++) begin
            if ((state_q[i] == S_DONE) && rsp_ready[i]) begin
                state_d[i] = S_IDLE;
            end
        end

        if (ret_vld) begin
            state_d[ret_id]   = S_DONE;
            rsp_y_d[ret_id]   = add_y;
            rsp_ovf_d[ret_id] = add_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q         <= '0;
            issue_count_q <= '0;
            tag_vld_q     <= '0;
            rsp_ovf_q     <= '0;
            // NOTE: the small per-slot result array is reset because its contents are visible on rsp_y.
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= S_IDLE;
                rsp_y_q[i] <= '0;
            end
            for (int s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            issue_count_q <= issue_count_d;
            tag_vld_q     <= tag_vld_d;
            rsp_ovf_q     <= rsp_ovf_d;
            for (int i = 0; i < NREQ; i++) begin
                state_q[i] <= state_d[i];
                rsp_y_q[i] <= rsp_y_d[i];
            end
            for (int s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_y     = '0;
        busy      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i]       = (state_q[i] == S_DONE);
            rsp_y[32*i +: 32]  = rsp_y_q[i];
            busy               = busy | (state_q[i] != S_IDLE);
        end
    end

    assign rsp_ovf     = rsp_ovf_q;
    assign issue_count = issue_count_q;

    // A returning tag must always land on a slot that is waiting for it.
    always @(posedge clk) begin
        if (rstn && ret_vld) begin
            assert (state_q[ret_id] == S_BUSY);
        end
    end
endmodule

// File: tb/tb_fadd_share_arbiter.sv
// Bench for fadd_share_arbiter: a queue-based model checks all outputs every cycle,
// and directed sequences pin literal results, grant order, backpressure and reset.

module tb_fadd_share_arbiter;
    localparam int NREQ = 3;
    localparam int LAT  = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready, rsp_ovf;
    logic [32*NREQ-1:0]  req_x1, req_x2, rsp_y;
    logic                busy;
    logic [31:0]         issue_count;

    // Expected result of the operands currently presented by each requester.
    logic [31:0]         exp_y_in   [NREQ];
    logic                exp_ovf_in [NREQ];

    int vectors     = 0;
    int miscompares = 0;

    fadd_share_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x1      (req_x1),
        .req_x2      (req_x2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_ovf     (rsp_ovf),
        .busy        (busy),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        int          rem;
        logic [31:0] y;
        logic        ovf;
    } pend_t;

    pend_t       m_pend [$];
    bit          m_out  [NREQ];
    bit          m_done [NREQ];
    logic [31:0] m_y    [NREQ];
    logic        m_ovf  [NREQ];
    int          m_ptr;
    logic [31:0] m_count;
    bit          m_known = 1'b0;

    initial begin : model
        int              g;
        logic [NREQ-1:0] er, ev;
        bit              eb;
        pend_t           t;
        forever begin
            @(negedge clk);
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ] && !m_out[(m_ptr + k) % NREQ])
                    g = (m_ptr + k) % NREQ;
            end
            if (m_known) begin
                er = '0;
                if (g >= 0) er[g] = 1'b1;
                ev = '0;
                eb = 1'b0;
                for (int i = 0; i < NREQ; i++) begin
                    ev[i] = m_done[i];
                    eb    = eb | m_out[i];
                end
                check("req_ready", 32'(req_ready), 32'(er));
                check("rsp_valid", 32'(rsp_valid), 32'(ev));
                check("busy", 32'(busy), 32'(eb));
                check("issue_count", issue_count, m_count);
                for (int i = 0; i < NREQ; i++) begin
                    check($sformatf("rsp_y[%0d]", i), rsp_y[32*i +: 32], m_y[i]);
                    check($sformatf("rsp_ovf[%0d]", i), 32'(rsp_ovf[i]), 32'(m_ovf[i]));
                end
            end
            // Advance the model across the coming rising edge.
            if (!rstn) begin
                m_pend.delete();
                for (int i = 0; i < NREQ; i++) begin
                    m_out[i]  = 1'b0;
                    m_done[i] = 1'b0;
                    m_y[i]    = '0;
                    m_ovf[i]  = 1'b0;
                end
                m_ptr   = 0;
                m_count = '0;
                m_known = 1'b1;
            end else if (m_known) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (m_done[i] && rsp_ready[i]) begin
                        m_done[i] = 1'b0;
                        m_out[i]  = 1'b0;
                    end
                end
                for (int p = 0; p < m_pend.size(); p++) begin
                    t         = m_pend[p];
                    t.rem     = t.rem - 1;
                    m_pend[p] = t;
                end
                while (m_pend.size() > 0 && m_pend[0].rem == 0) begin
                    t              = m_pend.pop_front();
                    m_done[t.id]   = 1'b1;
                    m_y[t.id]      = t.y;
                    m_ovf[t.id]    = t.ovf;
                end
                if (g >= 0) begin
                    m_out[g] = 1'b1;
                    t.id  = g;
                    t.rem = LAT;
                    t.y   = exp_y_in[g];
                    t.ovf = exp_ovf_in[g];
                    m_pend.push_back(t);
                    m_ptr   = (g + 1) % NREQ;
                    m_count = m_count + 32'd1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ey, input logic eo);
        req_x1[32*i +: 32] = a;
        req_x2[32*i +: 32] = b;
        exp_y_in[i]        = ey;
        exp_ovf_in[i]      = eo;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int k;
        int cnt;
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_x1    = '0;
        req_x2    = '0;
        for (int i = 0; i < NREQ; i++) begin
            exp_y_in[i]   = '0;
            exp_ovf_in[i] = 1'b0;
        end
        tick(3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_issue_count", issue_count, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        rstn = 1'b1;
        tick(1);

        // Single op: 1.0 + 2.0
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        req_valid[0] = 1'b1;
        #1 check("single_grant", 32'(req_ready), 32'h1);
        tick(1);
        req_valid[0] = 1'b0;
        #1 check("single_busy", 32'(busy), 32'h1);
        tick(1);
        check("single_not_yet", 32'(rsp_valid), 32'h0);
        tick(1);
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_y", rsp_y[31:0], 32'h4040_0000);
        check("single_rsp_ovf", 32'(rsp_ovf[0]), 32'h0);
        check("single_issue_count", issue_count, 32'h1);
        rsp_ready[0] = 1'b1;
        tick(1);
        rsp_ready[0] = 1'b0;
        check("single_consumed", 32'(rsp_valid), 32'h0);
        check("single_y_held", rsp_y[31:0], 32'h4040_0000);

        // Contention from reset: 2+2 on req0, 1+(-1) on req1
        do_reset();
        set_op(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
        set_op(1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0);
        req_valid = 3'b011;
        rsp_ready = 3'b011;
        #1 check("cont_grant0", 32'(req_ready), 32'h1);
        tick(1);
        req_valid[0] = 1'b0;
        #1 check("cont_grant1", 32'(req_ready), 32'h2);
        tick(1);
        req_valid[1] = 1'b0;
        tick(1);
        check("cont_rsp0_valid", 32'(rsp_valid), 32'h1);
        check("cont_rsp0_y", rsp_y[31:0], 32'h4080_0000);
        tick(1);
        check("cont_rsp1_valid", 32'(rsp_valid), 32'h2);
        check("cont_rsp1_y", rsp_y[63:32], 32'h0000_0000);
        check("cont_issue_count", issue_count, 32'h2);
        tick(1);
        rsp_ready = '0;

        // Overflow: max finite + max finite
        set_op(1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b1);
        req_valid[1] = 1'b1;
        tick(1);
        req_valid[1] = 1'b0;
        tick(2);
        check("ovf_rsp_valid", 32'(rsp_valid[1]), 32'h1);
        check("ovf_rsp_y", rsp_y[63:32], 32'h7F80_0000);
        check("ovf_rsp_ovf", 32'(rsp_ovf[1]), 32'h1);
        rsp_ready[1] = 1'b1;
        tick(1);
        rsp_ready[1] = 1'b0;

        // Backpressure on req0 while req1 keeps cycling
        set_op(0, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 1'b0);
        set_op(1, 32'hC000_0000, 32'h3F00_0000, 32'hBFC0_0000, 1'b0);
        rsp_ready = 3'b010;
        req_valid = 3'b011;
        k = 0;
        while (k < 10 && !rsp_valid[0]) begin
            tick(1);
            k++;
        end
        check("bp_rsp0_arrived", 32'(rsp_valid[0]), 32'h1);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            check("bp_no_regrant0", 32'(req_ready[0]), 32'h0);
            check("bp_y0_stable", rsp_y[31:0], 32'h3F80_0002);
            if (req_ready[1]) cnt++;
            tick(1);
        end
        check("bp_req1_granted", 32'(cnt >= 1), 32'h1);
        req_valid = '0;
        rsp_ready = 3'b111;
        tick(6);
        rsp_ready = '0;

        // Reset one cycle after an accept
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        req_valid[0] = 1'b1;
        #1 check("rmf_grant", 32'(req_ready[0]), 32'h1);
        tick(1);
        req_valid[0] = 1'b0;
        tick(1);
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        check("rmf_busy", 32'(busy), 32'h0);
        check("rmf_issue_count", issue_count, 32'h0);
        for (int c = 0; c < 6; c++) begin
            check("rmf_no_rsp", 32'(rsp_valid), 32'h0);
            tick(1);
        end

        // Fairness: all requesters valid, responses always taken
        do_reset();
        set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        set_op(1, 32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0);
        set_op(2, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 1'b0);
        rsp_ready = 3'b111;
        req_valid = 3'b111;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (req_ready != '0) begin
                check("fair_rotation", 32'(req_ready), 32'(3'b001 << (k % 3)));
                k++;
            end
            tick(1);
        end
        check("fair_grant_count", 32'(k), 32'd18);
        req_valid = '0;
        tick(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
